// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default fixed-point format, tap count, bias
// address, and helper functions for the signed saturation limits.
package cnn_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FRAC_BITS  = 16;
    localparam int unsigned NUM_TAPS       = 9;
    localparam logic [3:0]  BIAS_ADDR      = 4'd9;

    // Largest value representable in a w-bit two's complement word.
    function automatic longint sat_max_of(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic longint sat_min_of(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/conv_window3x3.sv
// 3x3 sliding window over a raster pixel stream.
// Two WIDTH-deep line buffers feed the top and middle rows of a 3x3
// register array; the bottom row takes the incoming pixel directly.
// Everything shifts only when en is high.
// Ports: clk, en (shift enable), din (pixel), taps (row-major, 0 = top-left).
module conv_window3x3
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WIDTH      = 28
) (
    input  logic                                 clk,
    input  logic                                 en,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  taps
);

    logic [DATA_WIDTH-1:0] lb_mid [WIDTH];
    logic [DATA_WIDTH-1:0] lb_top [WIDTH];
    logic [DATA_WIDTH-1:0] win    [3][3];

    // Line buffers and window carry no reset: contents are only consumed
    // once a full window has been shifted in.
    always_ff @(posedge clk) begin
        if (en) begin
            lb_mid[0] <= din;
            lb_top[0] <= lb_mid[WIDTH-1];
            for (int i = 1; i < int'(WIDTH); i++) begin
                lb_mid[i] <= lb_mid[i-1];
                lb_top[i] <= lb_top[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_top[WIDTH-1];
            win[1][2] <= lb_mid[WIDTH-1];
            win[2][2] <= din;
        end
    end

    // Flatten window to row-major tap order.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                taps[r*3+c] = win[r][c];
            end
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-only convolution with bias, fixed-point rescale and
// saturation. Output latency is two cycles after the window-completing pixel.
// Optional build macro CONV3X3_RELU_EN clamps negative results to zero.
// Ports: clk, resetn (async active-low), valid_in/data_in (pixel stream),
//        ack (frame abort), weight_we/weight_addr/weight_data (coefficient
//        write, idle only), busy, data_out/valid_out/done (result stream).
module conv3x3_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned HEIGHT     = 28
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ack,
    input  logic                  weight_we,
    input  logic [3:0]            weight_addr,
    input  logic [DATA_WIDTH-1:0] weight_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  done
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_W  = 2 * DATA_WIDTH + 4;
    localparam int unsigned COL_W  = $clog2(WIDTH);
    localparam int unsigned ROW_W  = $clog2(HEIGHT);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max_of(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min_of(DATA_WIDTH));

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept_c;
    logic             col_last_c;
    logic             row_last_c;
    logic             win_done_c;

    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps;
    logic signed [DATA_WIDTH-1:0] coef [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [PROD_W-1:0]     prod [NUM_TAPS];

    logic win_vld, win_last, s1_vld, s1_last;

    logic signed [ACC_W-1:0]      acc_c;
    logic signed [ACC_W-1:0]      shr_c;
    logic signed [ACC_W-1:0]      sat_c;
    logic        [DATA_WIDTH-1:0] result_c;

    // ack drops any pixel presented in the same cycle.
    assign accept_c   = valid_in & ~ack;
    assign col_last_c = (col == COL_W'(WIDTH - 1));
    assign row_last_c = (row == ROW_W'(HEIGHT - 1));
    assign win_done_c = accept_c && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Raster position of the next incoming pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (ack) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    conv_window3x3 #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIDTH      (WIDTH)
    ) u_window (
        .clk  (clk),
        .en   (accept_c),
        .din  (data_in),
        .taps (taps)
    );

    // Coefficient registers, writable only while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                coef[i] <= '0;
            end
            bias <= '0;
        end else if (weight_we && !busy) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                if (weight_addr == 4'(i)) begin
                    coef[i] <= weight_data;
                end
            end
            if (weight_addr == BIAS_ADDR) begin
                bias <= weight_data;
            end
        end
    end

    // Stage 1: products of the window captured on the previous cycle.
    always_ff @(posedge clk) begin
        if (win_vld) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                prod[i] <= PROD_W'($signed(taps[i])) * PROD_W'(coef[i]);
            end
        end
    end

    // Stage 2 datapath: sum, bias, rescale (floor), saturate.
    always_comb begin
        acc_c = '0;
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
            acc_c = acc_c + ACC_W'(prod[i]);
        end
        acc_c = acc_c + (ACC_W'(bias) <<< FRAC_BITS);
        shr_c = acc_c >>> FRAC_BITS;
        if (shr_c > SAT_MAX) begin
            sat_c = SAT_MAX;
        end else if (shr_c < SAT_MIN) begin
            sat_c = SAT_MIN;
        end else begin
            sat_c = shr_c;
        end
        result_c = DATA_WIDTH'(sat_c);
`ifdef CONV3X3_RELU_EN
        if (sat_c[ACC_W-1]) begin
            result_c = '0;
        end
`endif
    end

    // Pipeline valids, frame-end marker and busy tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_vld   <= 1'b0;
            win_last  <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            data_out  <= '0;
        end else if (ack) begin
            win_vld   <= 1'b0;
            win_last  <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            win_vld   <= win_done_c;
            win_last  <= win_done_c && col_last_c && row_last_c;
            s1_vld    <= win_vld;
            s1_last   <= win_last;
            valid_out <= s1_vld;
            done      <= s1_last;
            if (s1_vld) begin
                data_out <= result_c;
            end
            // A frame in progress keeps busy high past the previous frame's done.
            if (valid_in) begin
                busy <= 1'b1;
            end else if (done && (col == '0) && (row == '0)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: 4x4 frames on a 32-bit instance
// (scoreboard with latency and done checks) and an 8-bit instance for
// saturation. Honours CONV3X3_RELU_EN when defined.
module tb_conv3x3_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int FRAC = 0;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        longint value;
        longint due;
        bit     last;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_in;
    logic [31:0] data_in;
    logic        ack;
    logic        weight_we;
    logic [3:0]  weight_addr;
    logic [31:0] weight_data;
    logic        busy;
    logic [31:0] data_out;
    logic        valid_out;
    logic        done;

    logic [7:0]  data_in8;
    logic [7:0]  weight_data8;
    logic        busy8;
    logic [7:0]  data_out8;
    logic        valid_out8;
    logic        done8;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    exp_t   sb[$];
    exp_t   mon_e;

    longint mimg [H][W];
    longint mtap [9];
    longint mbias;
    int     mrow, mcol;

    bit     sat_on = 1'b0;
    longint sat_exp = 0;
    int     sat_cnt = 0;
    logic [7:0] px8 = 8'd0;

    conv3x3_stream #(
        .DATA_WIDTH (32), .FRAC_BITS (FRAC), .WIDTH (W), .HEIGHT (H)
    ) dut (
        .clk (clk), .resetn (resetn), .valid_in (valid_in), .data_in (data_in),
        .ack (ack), .weight_we (weight_we), .weight_addr (weight_addr),
        .weight_data (weight_data), .busy (busy), .data_out (data_out),
        .valid_out (valid_out), .done (done)
    );

    conv3x3_stream #(
        .DATA_WIDTH (8), .FRAC_BITS (0), .WIDTH (W), .HEIGHT (H)
    ) dut8 (
        .clk (clk), .resetn (resetn), .valid_in (valid_in), .data_in (data_in8),
        .ack (ack), .weight_we (weight_we), .weight_addr (weight_addr),
        .weight_data (weight_data8), .busy (busy8), .data_out (data_out8),
        .valid_out (valid_out8), .done (done8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_out(input int r, input int c);
        longint acc = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc += mimg[r-2+i][c-2+j] * mtap[i*3+j];
        acc += mbias <<< FRAC;
        acc = acc >>> FRAC;
        if (acc > MAXV) acc = MAXV;
        else if (acc < MINV) acc = MINV;
`ifdef CONV3X3_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic send_pixel(input longint v);
        exp_t e;
        @(negedge clk);
        valid_in  = 1'b1;
        data_in   = 32'(v);
        data_in8  = px8;
        ack       = 1'b0;
        weight_we = 1'b0;
        mimg[mrow][mcol] = v;
        if (mrow >= 2 && mcol >= 2) begin
            e.value = model_out(mrow, mcol);
            e.due   = cyc + 3;
            e.last  = (mrow == H-1) && (mcol == W-1);
            sb.push_back(e);
        end
        if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in  = 1'b0;
            ack       = 1'b0;
            weight_we = 1'b0;
        end
    endtask

    task automatic write_coef(input int addr, input longint d32, input longint d8,
                              input bit applied);
        @(negedge clk);
        valid_in     = 1'b0;
        ack          = 1'b0;
        weight_we    = 1'b1;
        weight_addr  = 4'(addr);
        weight_data  = 32'(d32);
        weight_data8 = 8'(d8);
        if (applied) begin
            if (addr < 9) mtap[addr] = d32;
            else mbias = d32;
        end
    endtask

    task automatic send_frame(input longint base, input int max_gap);
        for (int i = 1; i <= W*H; i++) begin
            send_pixel(base + i);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", longint'(sb.size()), 0);
        idle(2);
    endtask

    // Output monitor: pops the scoreboard on every result.
    always @(negedge clk) begin
        if (resetn) begin
            if (valid_out) begin
                check("out_expected", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("data", longint'($signed(data_out)), mon_e.value);
                    check("latency", cyc, mon_e.due);
                    check("done", longint'(done), longint'(mon_e.last));
                end
            end else if (done) begin
                check("done_no_valid", longint'(done), 0);
            end
            if (sat_on && valid_out8) begin
                check("sat8", longint'($signed(data_out8)), sat_exp);
                sat_cnt++;
            end
        end
    end

    initial begin
        resetn = 1'b0; valid_in = 1'b0; data_in = '0; ack = 1'b0;
        weight_we = 1'b0; weight_addr = '0; weight_data = '0;
        data_in8 = '0; weight_data8 = '0;
        mrow = 0; mcol = 0; mbias = 0;
        for (int i = 0; i < 9; i++) mtap[i] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", longint'(data_out), 0);
        check("rst_valid", longint'(valid_out), 0);
        check("rst_done", longint'(done), 0);
        check("rst_busy", longint'(busy), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Unit taps, zero bias; 8-bit instance saturating positive
        for (int i = 0; i < 9; i++) write_coef(i, 1, 127, 1'b1);
        write_coef(9, 0, 0, 1'b1);
        px8 = 8'd127; sat_exp = 127; sat_cnt = 0; sat_on = 1'b1;

        // Basic continuous frame
        send_frame(0, 0);
        idle(1);
        check("busy_mid", longint'(busy), 1);
        drain();
        check("sat_count_pos", sat_cnt, 4);
        check("busy_after_done", longint'(busy), 0);

        // Same frame with random bubbles
        send_frame(0, 2);
        drain();
        check("sat_count_bub", sat_cnt, 8);

        // Negative taps with bias; 8-bit instance saturating negative
        for (int i = 0; i < 9; i++) write_coef(i, -1, -128, 1'b1);
        write_coef(9, 10, 0, 1'b1);
`ifdef CONV3X3_RELU_EN
        sat_exp = 0;
`else
        sat_exp = -128;
`endif
        send_frame(0, 0);
        drain();
        check("sat_count_neg", sat_cnt, 12);
        sat_on = 1'b0;

        // ack abort after 7 pixels, ack colliding with a pixel
        for (int i = 0; i < 9; i++) write_coef(i, 1, 1, 1'b1);
        write_coef(9, 0, 0, 1'b1);
        for (int i = 1; i <= 7; i++) send_pixel(i);
        idle(1);
        check("busy_before_ack", longint'(busy), 1);
        @(negedge clk);
        ack = 1'b1; valid_in = 1'b1; data_in = 32'd999;
        mrow = 0; mcol = 0; sb.delete();
        idle(1);
        check("busy_after_ack", longint'(busy), 0);
        send_frame(0, 0);
        drain();

        // Write while busy is ignored; after done it applies
        for (int i = 1; i <= 5; i++) send_pixel(i);
        idle(1);
        write_coef(4, 100, 0, 1'b0);
        for (int i = 6; i <= 16; i++) send_pixel(i);
        drain();
        write_coef(4, 100, 0, 1'b1);
        // Back-to-back frames
        send_frame(0, 0);
        send_frame(16, 0);
        drain();

        // Reset mid-frame
        for (int i = 1; i <= 6; i++) send_pixel(i);
        @(negedge clk);
        valid_in = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rstmid_data", longint'(data_out), 0);
        check("rstmid_valid", longint'(valid_out), 0);
        check("rstmid_done", longint'(done), 0);
        check("rstmid_busy", longint'(busy), 0);
        check("rstmid_data8", longint'(data_out8), 0);
        check("rstmid_busy8", longint'(busy8), 0);
        check("rstmid_done8", longint'(done8), 0);
        sb.delete();
        mrow = 0; mcol = 0; mbias = 0;
        for (int i = 0; i < 9; i++) mtap[i] = 0;
        @(negedge clk);
        resetn = 1'b1;
        send_frame(0, 0);
        drain();
        check("busy_end", longint'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

- Streaming 3x3 convolution stage placed directly upstream of the pooling stage.
- Consumes a raster-order pixel stream of one WIDTH x HEIGHT feature map and produces a raster-order stream of (WIDTH-2) x (HEIGHT-2) convolved pixels, using valid-only windows with no padding.
- The output stream, with its `valid_out`/`done`, drives the pooling stage configured with WIDTH-2 x HEIGHT-2.
- Weights and bias are loaded through a simple write port while the block is idle.

## Interface
- DATA_WIDTH, 32, signed fixed-point width of pixels, weights, bias and output.
- FRAC_BITS, 16, fractional bits of the fixed-point format.
- WIDTH, 28, input map width in pixels (>=3).
- HEIGHT, 28, input map height in pixels (>=3).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- valid_in  in  1  data_in holds an accepted pixel this cycle.
- data_in  in  DATA_WIDTH  input pixel, signed.
- ack  in  1  frame abort: clears position counters and pipeline valids.
- weight_we  in  1  coefficient write strobe.
- weight_addr  in  4  0..8 = kernel taps in row-major order (0 = top-left); 9 = bias; 10..15 ignored.
- weight_data  in  DATA_WIDTH  coefficient value, signed.
- busy  out  1  high while a frame is partially received or the pipeline is non-empty.
- data_out  out  DATA_WIDTH  convolved pixel, signed.
- valid_out  out  1  one-cycle qualifier for data_out.
- done  out  1  pulses with valid_out of the last output pixel of a frame.

## Operation
- **Position counters:** col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on valid_in.
  - col wraps to 0 at WIDTH-1 and increments row.
  - After pixel (HEIGHT-1, WIDTH-1), both counters return to 0, ready for the next frame with no gap required.
- **Window:** two line buffers of WIDTH entries plus a 3x3 register array, all shifted only on valid_in. Bubbles (valid_in=0) freeze the window and the counters.
- **Window complete:** when the incoming pixel has row>=2 and col>=2.
- **Arithmetic:**
  - Stage 1 registers the nine signed products, each 2*DATA_WIDTH bits.
  - Stage 2 does the following:
    - sums the products into 2*DATA_WIDTH+4 bits;
    - adds the bias sign-extended and shifted left by FRAC_BITS;
    - arithmetic-shifts right by FRAC_BITS, truncating toward -inf;
    - saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Coefficient writes:**
  - Accepted only when busy=0. Writes while busy=1 are ignored.
  - Registers take effect from the next cycle.
  - Reset value of all coefficients is 0.
- **ack:**
  - Clears col, row, busy state and both pipeline valid bits in the same cycle.
  - Does not clear line buffer or coefficient contents.
  - ack and valid_in in the same cycle: ack wins, the pixel is dropped.
- **Reset (resetn=0):** all counters, pipeline valids, coefficients and outputs go to 0. data_out=0, valid_out=0, done=0, busy=0.

## Timing
- **Latency:** valid_out rises exactly 2 cycles after the valid_in cycle of the pixel completing a window. This holds regardless of later bubbles.
- **Throughput:** one pixel per cycle, no backpressure; the downstream stage must accept every valid_out.
- **valid_out:** a single-cycle pulse per window. data_out holds its last value when valid_out=0.
- **done:** coincides with the ((WIDTH-2)*(HEIGHT-2))-th valid_out of a frame, one cycle wide.
- **busy:**
  - rises in the cycle after the first accepted pixel of a frame;
  - falls the cycle after done;
  - falls the cycle after ack.
- **Back-to-back frames:** pixel 0 of frame N+1 may arrive in the cycle right after the last pixel of frame N. The pipeline drains frame N correctly while frame N+1 fills.
- **Reset mid-frame:** outputs go to 0 immediately, asynchronously. The next frame starts at (0,0).

## Configuration
- CONV3X3_RELU_EN defined: after saturation, negative results are replaced by 0 in stage 2. Latency is unchanged.
- CONV3X3_RELU_EN undefined: signed saturated result is output unchanged.

## Structure
- Shared package cnn_pkg holds:
  - the default DATA_WIDTH and FRAC_BITS;
  - the tap-count constant (9);
  - the bias address constant (9);
  - the saturation min/max helper constants.
- One sub-module, conv_window3x3: two line buffers plus the 3x3 register array, with enable=valid_in, exposing nine taps.
- Counters, coefficient registers, MAC pipeline and control stay in conv3x3_stream.

## Test plan
- **Basic frame:** FRAC_BITS=0, W=H=4, all taps 1, bias 0, pixels 1..16 with continuous valid -> outputs 54, 63, 90, 99, each 2 cycles after pixels 11, 12, 15, 16; done with 99.
- **Bubbles:** same frame with random valid_in gaps -> identical outputs 54, 63, 90, 99, each 2 cycles after its completing pixel; same total of 4 outputs.
- **ReLU and bias:** all taps -1, bias 10 -> first output 0 with CONV3X3_RELU_EN, -44 without.
- **Saturation:** DATA_WIDTH=8, FRAC_BITS=0, taps 127, pixels 127 -> every output 127. Taps -128, pixels 127 -> every output -128 without the macro.
- **ack abort:** assert ack after 7 pixels, then send a full 16-pixel frame -> no output before the new frame; then 54, 63, 90, 99 and one done.
- **Busy interlock:** a weight write mid-frame (busy=1) has no effect on outputs. The same write after done applies to the next frame. resetn pulse mid-frame -> all outputs 0, coefficients 0, busy=0.
